// File: rtl/mayo_keygen_axil_regs_if.sv
// rtl/mayo_keygen_axil_regs_if.sv - AXI4-Lite bus bundle between host master and the MAYO keygen register slave
interface mayo_keygen_axil_regs_if #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 5
);
    logic [C_S_AXI_ADDR_WIDTH-1:0]   awaddr;
    logic [2:0]                      awprot;
    logic                            awvalid;
    logic                            awready;
    logic [C_S_AXI_DATA_WIDTH-1:0]   wdata;
    logic [C_S_AXI_DATA_WIDTH/8-1:0] wstrb;
    logic                            wvalid;
    logic                            wready;
    logic [1:0]                      bresp;
    logic                            bvalid;
    logic                            bready;
    logic [C_S_AXI_ADDR_WIDTH-1:0]   araddr;
    logic [2:0]                      arprot;
    logic                            arvalid;
    logic                            arready;
    logic [C_S_AXI_DATA_WIDTH-1:0]   rdata;
    logic [1:0]                      rresp;
    logic                            rvalid;
    logic                            rready;

    modport master (
        output awaddr, awprot, awvalid, input awready,
        output wdata, wstrb, wvalid, input wready,
        input bresp, bvalid, output bready,
        output araddr, arprot, arvalid, input arready,
        input rdata, rresp, rvalid, output rready
    );

    modport slave (
        input awaddr, awprot, awvalid, output awready,
        input wdata, wstrb, wvalid, output wready,
        output bresp, bvalid, input bready,
        input araddr, arprot, arvalid, output arready,
        output rdata, rresp, rvalid, input rready
    );
endinterface

// File: rtl/mayo_keygen_axil_regs.sv
// rtl/mayo_keygen_axil_regs.sv - AXI4-Lite register file for the MAYO keygen FSM
// Four scratch/config registers, CTRL (start, irq enable) and STATUS (busy, sticky done).
module mayo_keygen_axil_regs #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 5
) (
    input  logic                          s00_axi_aclk,
    input  logic                          s00_axi_aresetn,
    mayo_keygen_axil_regs_if.slave        s00_axi,
    output logic                          keygen_start,
    input  logic                          keygen_busy,
    input  logic                          keygen_done,
    output logic [C_S_AXI_DATA_WIDTH-1:0] cfg_reg0,
    output logic [C_S_AXI_DATA_WIDTH-1:0] cfg_reg1,
    output logic [C_S_AXI_DATA_WIDTH-1:0] cfg_reg2,
    output logic [C_S_AXI_DATA_WIDTH-1:0] cfg_reg3,
    output logic                          irq
);
    localparam int DW = C_S_AXI_DATA_WIDTH;
    localparam int SW = C_S_AXI_DATA_WIDTH / 8;
    localparam int AW = C_S_AXI_ADDR_WIDTH;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [2:0] IDX_CTRL    = 3'd4;
    localparam logic [2:0] IDX_STATUS  = 3'd5;

    logic          r_ready_en;
    logic          r_aw_held;
    logic          r_w_held;
    logic [AW-1:0] r_awaddr;
    logic [DW-1:0] r_wdata;
    logic [SW-1:0] r_wstrb;
    logic          r_bvalid;
    logic [1:0]    r_bresp;
    logic          r_rvalid;
    logic [1:0]    r_rresp;
    logic [DW-1:0] r_rdata;
    logic [DW-1:0] r_reg [4];
    logic          r_irq_en;
    logic          r_done;
    logic          r_start;
    logic          r_irq;

    logic          w_awready;
    logic          w_wready;
    logic          w_arready;
    logic          w_aw_hs;
    logic          w_w_hs;
    logic          w_ar_hs;
    logic          w_commit;
    logic [AW-1:0] w_wr_addr;
    logic [DW-1:0] w_wr_data;
    logic [SW-1:0] w_wr_strb;
    logic [2:0]    w_wr_idx;
    logic [2:0]    w_rd_idx;
    logic          w_wr_mapped;
    logic          w_rd_mapped;
    logic          w_start_req;
    logic          w_done_clr;
    logic [DW-1:0] w_rd_data;
    logic          w_unused;

    function automatic logic [DW-1:0] f_merge(input logic [DW-1:0] old_v,
                                              input logic [DW-1:0] new_v,
                                              input logic [SW-1:0] strb);
        logic [DW-1:0] res;
        res = old_v;
        for (int i = 0; i < SW; i++) begin
            if (strb[i]) res[8*i +: 8] = new_v[8*i +: 8];
        end
        return res;
    endfunction

    // r_ready_en keeps every ready low while reset is applied and for the first edge after it.
    assign w_awready = r_ready_en && !r_aw_held && !r_bvalid;
    assign w_wready  = r_ready_en && !r_w_held && !r_bvalid;
    assign w_arready = r_ready_en && !r_rvalid;

    assign w_aw_hs = s00_axi.awvalid && w_awready;
    assign w_w_hs  = s00_axi.wvalid && w_wready;
    assign w_ar_hs = s00_axi.arvalid && w_arready;

    // A beat arriving this cycle counts as held, so AW+W together commit immediately.
    assign w_wr_addr = r_aw_held ? r_awaddr : s00_axi.awaddr;
    assign w_wr_data = r_w_held ? r_wdata : s00_axi.wdata;
    assign w_wr_strb = r_w_held ? r_wstrb : s00_axi.wstrb;
    assign w_commit  = (r_aw_held || w_aw_hs) && (r_w_held || w_w_hs) && !r_bvalid;

    assign w_wr_idx    = w_wr_addr[4:2];
    assign w_rd_idx    = s00_axi.araddr[4:2];
    assign w_wr_mapped = (w_wr_idx <= IDX_STATUS);
    assign w_rd_mapped = (w_rd_idx <= IDX_STATUS);

    assign w_start_req = w_commit && (w_wr_idx == IDX_CTRL) && w_wr_strb[0]
                         && w_wr_data[0] && !keygen_busy;
    assign w_done_clr  = w_commit && (w_wr_idx == IDX_STATUS) && w_wr_strb[0] && w_wr_data[1];

    always_comb begin
        w_rd_data = '0;
        case (w_rd_idx)
            3'd0, 3'd1, 3'd2, 3'd3: w_rd_data = r_reg[w_rd_idx[1:0]];
            IDX_CTRL:               w_rd_data[1] = r_irq_en;
            IDX_STATUS: begin
                w_rd_data[0] = keygen_busy;
                w_rd_data[1] = r_done;
            end
            default:                w_rd_data = '0;
        endcase
    end

    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            r_ready_en <= 1'b0;
            r_aw_held  <= 1'b0;
            r_w_held   <= 1'b0;
            r_awaddr   <= '0;
            r_wdata    <= '0;
            r_wstrb    <= '0;
            r_bvalid   <= 1'b0;
            r_bresp    <= RESP_OKAY;
        end else begin
            r_ready_en <= 1'b1;
            if (w_aw_hs) r_awaddr <= s00_axi.awaddr;
            if (w_w_hs) begin
                r_wdata <= s00_axi.wdata;
                r_wstrb <= s00_axi.wstrb;
            end
            r_aw_held <= !w_commit && (r_aw_held || w_aw_hs);
            r_w_held  <= !w_commit && (r_w_held || w_w_hs);
            if (w_commit) begin
                r_bvalid <= 1'b1;
                r_bresp  <= w_wr_mapped ? RESP_OKAY : RESP_SLVERR;
            end else if (s00_axi.bready) begin
                r_bvalid <= 1'b0;
            end
        end
    end

    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            for (int i = 0; i < 4; i++) r_reg[i] <= '0;
            r_irq_en <= 1'b0;
            r_start  <= 1'b0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (w_commit && (w_wr_idx == 3'(i))) begin
                    r_reg[i] <= f_merge(r_reg[i], w_wr_data, w_wr_strb);
                end
            end
            if (w_commit && (w_wr_idx == IDX_CTRL) && w_wr_strb[0]) r_irq_en <= w_wr_data[1];
            r_start <= w_start_req;
        end
    end

    // A done pulse from the FSM wins over a simultaneous host W1C so no completion is lost.
    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            r_done <= 1'b0;
            r_irq  <= 1'b0;
        end else begin
            if (keygen_done)     r_done <= 1'b1;
            else if (w_done_clr) r_done <= 1'b0;
            r_irq <= r_done && r_irq_en;
        end
    end

    // Read data is captured from pre-edge state, so a same-cycle write is not yet visible.
    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            r_rvalid <= 1'b0;
            r_rresp  <= RESP_OKAY;
            r_rdata  <= '0;
        end else if (w_ar_hs) begin
            r_rvalid <= 1'b1;
            r_rresp  <= w_rd_mapped ? RESP_OKAY : RESP_SLVERR;
            r_rdata  <= w_rd_data;
        end else if (s00_axi.rready) begin
            r_rvalid <= 1'b0;
        end
    end

    assign s00_axi.awready = w_awready;
    assign s00_axi.wready  = w_wready;
    assign s00_axi.bvalid  = r_bvalid;
    assign s00_axi.bresp   = r_bresp;
    assign s00_axi.arready = w_arready;
    assign s00_axi.rvalid  = r_rvalid;
    assign s00_axi.rresp   = r_rresp;
    assign s00_axi.rdata   = r_rdata;

    assign keygen_start = r_start;
    assign irq          = r_irq;
    assign cfg_reg0     = r_reg[0];
    assign cfg_reg1     = r_reg[1];
    assign cfg_reg2     = r_reg[2];
    assign cfg_reg3     = r_reg[3];

    assign w_unused = ^{s00_axi.awprot, s00_axi.arprot, w_wr_addr[1:0], s00_axi.araddr[1:0]};
endmodule
